ex_stage_md: RTL

- Parametrised next-generation execute stage for the five-stage MIPS pipeline.
- Same datapath as the current EX stage: forwarding muxes, ALU, immediate select and link-address insert.
- Adds a multi-cycle multiply/divide unit with HI/LO registers, a busy/stall handshake to the hazard unit, and mfhi/mflo result selection.
- Sits between the ID/EX and EX/MEM pipeline registers.

---
 rtl/ex_pkg.sv | 68 ++++++
 rtl/ex_stage_md_md_unit.sv | 166 ++++++++++++++++
 rtl/ex_stage_md.sv | 124 ++++++++++++
 3 files changed

// File: rtl/ex_pkg.sv
// ex_pkg: shared encodings for the execute stage and its multiply/divide unit.
//   alu_op_e   : ALU operation codes driven by the decoder
//   md_op_e    : multiply/divide operation codes
//   res_sel_e  : stage result source select (ALU/link, HI, LO)
//   md_state_e : multiply/divide FSM states
//   fwd_*      : forwarding mux select codes (3 also selects the register value)
// Optional feature macro EX_MADD_EN: makes MADD/MADDU/MSUB/MSUBU multi-cycle ops.
package ex_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4,
      ALU_SLT = 3'd5,
      ALU_SLL = 3'd6,
      ALU_SRL = 3'd7
   } alu_op_e;

   typedef enum logic [3:0] {
      MD_NONE  = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_DIV   = 4'd3,
      MD_DIVU  = 4'd4,
      MD_MTHI  = 4'd5,
      MD_MTLO  = 4'd6,
      MD_MADD  = 4'd7,
      MD_MADDU = 4'd8,
      MD_MSUB  = 4'd9,
      MD_MSUBU = 4'd10
   } md_op_e;

   typedef enum logic [1:0] {
      RES_ALU = 2'd0,
      RES_HI  = 2'd1,
      RES_LO  = 2'd2
   } res_sel_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } md_state_e;

   localparam logic [1:0] FWD_REG = 2'd0;
   localparam logic [1:0] FWD_MEM = 2'd1;
   localparam logic [1:0] FWD_WB  = 2'd2;

   // Ops that occupy the multiplier for MULT_LAT cycles.  The accumulate
   // forms only count when the accumulate feature is built in; otherwise
   // they fall through as no-ops.
   function automatic logic is_mul_op(input logic [3:0] op);
      logic r;
      r = (op == MD_MULT) || (op == MD_MULTU);
`ifdef EX_MADD_EN
      r = r || (op == MD_MADD) || (op == MD_MADDU) ||
               (op == MD_MSUB) || (op == MD_MSUBU);
`endif
      return r;
   endfunction

   function automatic logic is_div_op(input logic [3:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/ex_stage_md_md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers.
//   clk, reset    : clock, synchronous active-high reset (discards any pending op)
//   start, op     : request valid and md_op code; only sampled in IDLE
//   src_a, src_b  : operands (src_a also feeds MTHI/MTLO)
//   busy          : operation in progress (exactly LAT cycles per op)
//   stall         : busy, or a multi-cycle request is being presented this cycle
//   hi, lo        : architectural HI/LO registers
//   state_dbg     : current FSM state (md_state_e encoding)
// Handshake: a request is accepted at the rising edge where start=1, the FSM is
// IDLE and op is a recognised code; while busy, start is ignored (the hazard
// unit holds new requests off using stall).
// Optional feature macro EX_MADD_EN enables MADD/MADDU/MSUB/MSUBU.
module md_unit
   import ex_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [3:0]        op,
   input  logic [DATA_W-1:0] src_a,
   input  logic [DATA_W-1:0] src_b,
   output logic              busy,
   output logic              stall,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo,
   output logic [1:0]        state_dbg
);

   localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);

   md_state_e         state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [DATA_W-1:0] a_q, a_n, b_q, b_n;
   logic [3:0]        op_q, op_n;
   logic [DATA_W-1:0] hi_q, hi_n, lo_q, lo_n;

   // Multiply: sign/zero-extend to 2*DATA_W so one multiplier covers both
   // the signed and unsigned forms (low 2*DATA_W bits are exact either way).
   logic                mul_sgn;
   logic [2*DATA_W-1:0] ext_a, ext_b, prod, mul_res;

   // Divide: signed ops divide magnitudes and then fix up the signs, giving
   // truncation toward zero and a remainder with the dividend's sign.
   // Most-negative / -1 naturally yields quotient = most-negative, rem = 0.
   logic              div_sgn, a_neg, b_neg;
   logic [DATA_W-1:0] abs_a, abs_b, div_b, uq, ur, quo, rem;

   always_comb begin
      mul_sgn = (op_q == MD_MULT) || (op_q == MD_MADD) || (op_q == MD_MSUB);
      ext_a   = mul_sgn ? {{DATA_W{a_q[DATA_W-1]}}, a_q} : {{DATA_W{1'b0}}, a_q};
      ext_b   = mul_sgn ? {{DATA_W{b_q[DATA_W-1]}}, b_q} : {{DATA_W{1'b0}}, b_q};
      prod    = ext_a * ext_b;
`ifdef EX_MADD_EN
      case (op_q)
         MD_MADD, MD_MADDU: mul_res = {hi_q, lo_q} + prod;
         MD_MSUB, MD_MSUBU: mul_res = {hi_q, lo_q} - prod;
         default:           mul_res = prod;
      endcase
`else
      mul_res = prod;
`endif
   end

   always_comb begin
      div_sgn = (op_q == MD_DIV);
      a_neg   = div_sgn & a_q[DATA_W-1];
      b_neg   = div_sgn & b_q[DATA_W-1];
      abs_a   = a_neg ? (~a_q + 1'b1) : a_q;
      abs_b   = b_neg ? (~b_q + 1'b1) : b_q;
      // Keep the divider free of X when dividing by zero; the result is
      // discarded in that case anyway.
      div_b   = (abs_b == '0) ? {{(DATA_W-1){1'b0}}, 1'b1} : abs_b;
      uq      = abs_a / div_b;
      ur      = abs_a % div_b;
      quo     = (a_neg ^ b_neg) ? (~uq + 1'b1) : uq;
      rem     = a_neg ? (~ur + 1'b1) : ur;
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      a_n     = a_q;
      b_n     = b_q;
      op_n    = op_q;
      hi_n    = hi_q;
      lo_n    = lo_q;
      case (state)
         ST_IDLE: begin
            if (start) begin
               if (is_mul_op(op)) begin
                  state_n = ST_MUL;
                  cnt_n   = CNT_W'(MULT_LAT - 1);
                  a_n     = src_a;
                  b_n     = src_b;
                  op_n    = op;
               end else if (is_div_op(op)) begin
                  state_n = ST_DIV;
                  cnt_n   = CNT_W'(DIV_LAT - 1);
                  a_n     = src_a;
                  b_n     = src_b;
                  op_n    = op;
               end else if (op == MD_MTHI) begin
                  hi_n = src_a;
               end else if (op == MD_MTLO) begin
                  lo_n = src_a;
               end
            end
         end
         ST_MUL: begin
            if (cnt == '0) begin
               state_n      = ST_IDLE;
               {hi_n, lo_n} = mul_res;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         ST_DIV: begin
            if (cnt == '0) begin
               state_n = ST_IDLE;
               if (b_q != '0) begin
                  hi_n = rem;
                  lo_n = quo;
               end
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         default: begin
            state_n = ST_IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
         a_q   <= '0;
         b_q   <= '0;
         op_q  <= MD_NONE;
         hi_q  <= '0;
         lo_q  <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         a_q   <= a_n;
         b_q   <= b_n;
         op_q  <= op_n;
         hi_q  <= hi_n;
         lo_q  <= lo_n;
      end
   end

   assign busy      = (state != ST_IDLE);
   assign stall     = busy | (start & (is_mul_op(op) | is_div_op(op)));
   assign hi        = hi_q;
   assign lo        = lo_q;
   assign state_dbg = state;

endmodule

// File: rtl/ex_stage_md.sv
// ex_stage_md: execute stage with forwarding, ALU, link insert and a
// multi-cycle multiply/divide unit with HI/LO.
//   pc_in/instr_in            : instruction PC/word (shamt = instr_in[10:6]), passed through
//   rs_data_in/rt_data_in     : register-file operands
//   fwd_rs_sel/fwd_rt_sel     : 0,3 = register, 1 = MEM, 2 = WB forwarded value
//   imm_in, alu_src           : immediate and srcB select
//   alu_op                    : ALU operation (ex_pkg::alu_op_e)
//   write_r31                 : result is pc_in + LINK_OFF
//   md_op/md_start            : multiply/divide request
//   res_sel                   : 0 = ALU/link, 1 = HI, 2 = LO
//   md_busy/md_stall          : unit busy / stall request to the hazard unit
//   result_out, rt_data_out   : stage result and forwarded store data
//   md_state                  : multiply/divide FSM state for observation
// The datapath is fully combinational; only HI/LO and the FSM are registered.
// Optional feature macro EX_MADD_EN enables MADD/MADDU/MSUB/MSUBU.
module ex_stage_md
   import ex_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10,
   parameter int LINK_OFF = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       pc_in,
   input  logic [31:0]       instr_in,
   input  logic [DATA_W-1:0] rs_data_in,
   input  logic [DATA_W-1:0] rt_data_in,
   input  logic [DATA_W-1:0] imm_in,
   input  logic [1:0]        fwd_rs_sel,
   input  logic [1:0]        fwd_rt_sel,
   input  logic [DATA_W-1:0] fwd_mem_data,
   input  logic [DATA_W-1:0] fwd_wb_data,
   input  logic [2:0]        alu_op,
   input  logic              alu_src,
   input  logic              write_r31,
   input  logic [3:0]        md_op,
   input  logic              md_start,
   input  logic [1:0]        res_sel,
   output logic              md_busy,
   output logic              md_stall,
   output logic [31:0]       pc_out,
   output logic [31:0]       instr_out,
   output logic [DATA_W-1:0] result_out,
   output logic [DATA_W-1:0] rt_data_out,
   output logic [1:0]        md_state
);

   logic [DATA_W-1:0] fwd_rs, fwd_rt, src_a, src_b, alu_res, hi, lo, link_val;
   logic [31:0]       link_pc;
   logic [4:0]        shamt;

   always_comb begin
      case (fwd_rs_sel)
         FWD_MEM: fwd_rs = fwd_mem_data;
         FWD_WB:  fwd_rs = fwd_wb_data;
         default: fwd_rs = rs_data_in;
      endcase
      case (fwd_rt_sel)
         FWD_MEM: fwd_rt = fwd_mem_data;
         FWD_WB:  fwd_rt = fwd_wb_data;
         default: fwd_rt = rt_data_in;
      endcase
   end

   assign src_a = fwd_rs;
   assign src_b = alu_src ? imm_in : fwd_rt;
   assign shamt = instr_in[10:6];

   // Shifts act on srcB by the instruction's shamt field, as in sll/srl.
   always_comb begin
      case (alu_op)
         ALU_ADD: alu_res = src_a + src_b;
         ALU_SUB: alu_res = src_a - src_b;
         ALU_AND: alu_res = src_a & src_b;
         ALU_OR:  alu_res = src_a | src_b;
         ALU_XOR: alu_res = src_a ^ src_b;
         ALU_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         ALU_SLL: alu_res = src_b << shamt;
         ALU_SRL: alu_res = src_b >> shamt;
         default: alu_res = '0;
      endcase
   end

   // Link address is formed at PC width, then zero-extended or truncated.
   assign link_pc  = pc_in + 32'(LINK_OFF);
   assign link_val = DATA_W'(link_pc);

   always_comb begin
      if (write_r31) begin
         result_out = link_val;
      end else begin
         case (res_sel)
            RES_HI:  result_out = hi;
            RES_LO:  result_out = lo;
            default: result_out = alu_res;
         endcase
      end
   end

   md_unit #(
      .DATA_W   (DATA_W),
      .MULT_LAT (MULT_LAT),
      .DIV_LAT  (DIV_LAT)
   ) u_md (
      .clk       (clk),
      .reset     (reset),
      .start     (md_start),
      .op        (md_op),
      .src_a     (src_a),
      .src_b     (src_b),
      .busy      (md_busy),
      .stall     (md_stall),
      .hi        (hi),
      .lo        (lo),
      .state_dbg (md_state)
   );

   assign pc_out      = pc_in;
   assign instr_out   = instr_in;
   assign rt_data_out = fwd_rt;

endmodule
